snn_layer_sequencer: RTL and testbench

Run-level scheduler for the spiking-network datapath: holds a small table of layer descriptors and, for each timestep and each layer in turn, configures and launches the matrix-multiply engine (synaptic current) and then the matrix LIF engine (spike generation), waiting for each engine's `done` before moving on. It sits between the host/config bus and the two matrix engines, which share the same on-chip SRAM regions through the addresses it programs.

---
 rtl/snn_layer_sequencer_pkg.sv | 12 +
 rtl/snn_layer_sequencer_engine_handshake.sv | 28 ++
 rtl/snn_layer_sequencer.sv | 133 +++++++++++++
 tb/tb_snn_layer_sequencer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/snn_layer_sequencer_pkg.sv
// snn_layer_sequencer_pkg: shared constants, state encodings and helpers for the layer sequencer.
package snn_layer_sequencer_pkg;
  localparam int MAX_LAYERS = 8;
  localparam int ADDR_W = 14;
  localparam logic [2:0] F_IN_SPIKE = 3'd0, F_WEIGHT = 3'd1, F_CURRENT = 3'd2, F_OUT_SPIKE = 3'd3;
  localparam logic [2:0] F_ROWS = 3'd4, F_COLS = 3'd5, F_INNER = 3'd6, F_THRE = 3'd7;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MM, S_LIF, S_ADV, S_FIN} seq_state_t;
  typedef enum logic [1:0] {H_IDLE, H_LAUNCH, H_ACK, H_WAIT} hs_state_t;
  function automatic logic [3:0] clamp_layers(input logic [3:0] n);
    return (n > 4'(MAX_LAYERS)) ? 4'(MAX_LAYERS) : n;
  endfunction
endpackage

// File: rtl/snn_layer_sequencer_engine_handshake.sv
// engine_handshake: one start pulse, then wait for done to drop (accept) and rise again (complete).
module engine_handshake
  import snn_layer_sequencer_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_go,
  input  logic i_done,
  output logic o_start,
  output logic o_fin
);
  hs_state_t r_state;
  assign o_fin = (r_state == H_WAIT) && i_done;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= H_IDLE;
      o_start <= 1'b0;
    end else begin
      o_start <= (r_state == H_IDLE) && i_go;
      case (r_state)
        H_IDLE:   r_state <= i_go ? H_LAUNCH : H_IDLE;
        H_LAUNCH: r_state <= H_ACK;
        H_ACK:    r_state <= i_done ? H_ACK : H_WAIT;
        default:  r_state <= i_done ? H_IDLE : H_WAIT;
      endcase
    end
  end
endmodule

// File: rtl/snn_layer_sequencer.sv
// snn_layer_sequencer: walks timesteps x layers, configuring and launching matmul then LIF per layer.
module snn_layer_sequencer
  import snn_layer_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [2:0]        cfg_layer,
  input  logic [2:0]        cfg_field,
  input  logic [15:0]       cfg_wdata,
  input  logic              run_start,
  input  logic [3:0]        num_layers,
  input  logic [7:0]        num_steps,
  output logic              busy,
  output logic              run_done,
  output logic [7:0]        cur_step,
  output logic [2:0]        cur_layer,
  output logic              mm_start,
  input  logic              mm_done,
  output logic [ADDR_W-1:0] mm_src1_addr,
  output logic [ADDR_W-1:0] mm_src2_addr,
  output logic [ADDR_W-1:0] mm_dest_addr,
  output logic [9:0]        mm_src1_row,
  output logic [9:0]        mm_src1_col,
  output logic [5:0]        mm_src2_row,
  output logic [5:0]        mm_src2_col,
  output logic              lif_start,
  input  logic              lif_done,
  output logic [ADDR_W-1:0] lif_src_addr,
  output logic [ADDR_W-1:0] lif_dest_addr,
  output logic [9:0]        lif_row,
  output logic [9:0]        lif_col,
  output logic [15:0]       lif_thre
);
  logic [ADDR_W-1:0] r_addr [MAX_LAYERS][4];
  logic [9:0]        r_rows [MAX_LAYERS];
  logic [5:0]        r_cols [MAX_LAYERS];
  logic [9:0]        r_inner [MAX_LAYERS];
  logic [15:0]       r_thre [MAX_LAYERS];
  seq_state_t        r_state;
  logic [3:0]        r_nl;
  logic [7:0]        r_ns;
  logic              w_mm_fin, w_lif_fin, w_last_layer, w_last_step, w_empty, w_enter_load;
  logic [2:0]        w_load_layer;
  assign w_last_layer = {1'b0, cur_layer} == r_nl - 4'd1;
  assign w_last_step  = cur_step == r_ns - 8'd1;
  assign w_empty      = (num_layers == 4'd0) || (num_steps == 8'd0);
  // Config is captured on the edge that enters LOAD so it is stable a full cycle before start.
  assign w_load_layer = (r_state == S_ADV && !w_last_layer) ? cur_layer + 3'd1 : 3'd0;
  assign w_enter_load = (r_state == S_IDLE && run_start && !w_empty) ||
                        (r_state == S_ADV && !(w_last_layer && w_last_step));
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int l = 0; l < MAX_LAYERS; l++) begin
        for (int f = 0; f < 4; f++) r_addr[l][f] <= '0;
        r_rows[l]  <= '0;
        r_cols[l]  <= '0;
        r_inner[l] <= '0;
        r_thre[l]  <= '0;
      end
    end else if (cfg_we && !busy) begin
      case (cfg_field)
        F_ROWS:  r_rows[cfg_layer]  <= cfg_wdata[9:0];
        F_COLS:  r_cols[cfg_layer]  <= cfg_wdata[5:0];
        F_INNER: r_inner[cfg_layer] <= cfg_wdata[9:0];
        F_THRE:  r_thre[cfg_layer]  <= cfg_wdata;
        default: r_addr[cfg_layer][cfg_field[1:0]] <= cfg_wdata[ADDR_W-1:0];
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_nl <= '0;
      r_ns <= '0;
      busy <= 1'b0;
      run_done <= 1'b0;
      cur_step <= '0;
      cur_layer <= '0;
      {mm_src1_addr, mm_src2_addr, mm_dest_addr, mm_src1_row, mm_src1_col, mm_src2_row, mm_src2_col} <= '0;
      {lif_src_addr, lif_dest_addr, lif_row, lif_col, lif_thre} <= '0;
    end else begin
      run_done <= 1'b0;
      if (w_enter_load) begin
        mm_src1_addr  <= r_addr[w_load_layer][F_IN_SPIKE[1:0]];
        mm_src2_addr  <= r_addr[w_load_layer][F_WEIGHT[1:0]];
        mm_dest_addr  <= r_addr[w_load_layer][F_CURRENT[1:0]];
        mm_src1_row   <= r_rows[w_load_layer];
        mm_src1_col   <= r_inner[w_load_layer];
        mm_src2_row   <= r_inner[w_load_layer][5:0];
        mm_src2_col   <= r_cols[w_load_layer];
        lif_src_addr  <= r_addr[w_load_layer][F_CURRENT[1:0]];
        lif_dest_addr <= r_addr[w_load_layer][F_OUT_SPIKE[1:0]];
        lif_row       <= r_rows[w_load_layer];
        lif_col       <= {4'd0, r_cols[w_load_layer]};
        lif_thre      <= r_thre[w_load_layer];
      end
      case (r_state)
        S_IDLE: if (run_start) begin
          r_nl <= clamp_layers(num_layers);
          r_ns <= num_steps;
          cur_step <= '0;
          cur_layer <= '0;
          busy <= 1'b1;
          run_done <= w_empty;
          r_state <= w_empty ? S_FIN : S_LOAD;
        end
        S_LOAD: r_state <= S_MM;
        S_MM:   r_state <= w_mm_fin ? S_LIF : S_MM;
        S_LIF:  r_state <= w_lif_fin ? S_ADV : S_LIF;
        S_ADV: begin
          cur_layer <= w_load_layer;
          cur_step <= w_last_layer ? cur_step + 8'd1 : cur_step;
          run_done <= w_last_layer && w_last_step;
          r_state <= (w_last_layer && w_last_step) ? S_FIN : S_LOAD;
        end
        S_FIN: begin
          busy <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
  engine_handshake u_mm (
    .clk(clk), .reset(reset), .i_go(r_state == S_LOAD), .i_done(mm_done),
    .o_start(mm_start), .o_fin(w_mm_fin)
  );
  engine_handshake u_lif (
    .clk(clk), .reset(reset), .i_go(w_mm_fin), .i_done(lif_done),
    .o_start(lif_start), .o_fin(w_lif_fin)
  );
endmodule

// File: tb/tb_snn_layer_sequencer.sv
// tb_snn_layer_sequencer: directed+random runs against engine models and a layer-order reference model.
module tb_snn_layer_sequencer;
  logic clk = 1'b0, reset = 1'b1, cfg_we = 1'b0, run_start = 1'b0;
  logic [2:0] cfg_layer = '0, cfg_field = '0;
  logic [15:0] cfg_wdata = '0;
  logic [3:0] num_layers = '0;
  logic [7:0] num_steps = '0;
  logic busy, run_done, mm_start, mm_done, lif_start, lif_done;
  logic [7:0] cur_step;
  logic [2:0] cur_layer;
  logic [13:0] mm_src1_addr, mm_src2_addr, mm_dest_addr, lif_src_addr, lif_dest_addr;
  logic [9:0] mm_src1_row, mm_src1_col, lif_row, lif_col;
  logic [5:0] mm_src2_row, mm_src2_col;
  logic [15:0] lif_thre;
  snn_layer_sequencer dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_layer(cfg_layer), .cfg_field(cfg_field),
    .cfg_wdata(cfg_wdata), .run_start(run_start), .num_layers(num_layers), .num_steps(num_steps),
    .busy(busy), .run_done(run_done), .cur_step(cur_step), .cur_layer(cur_layer),
    .mm_start(mm_start), .mm_done(mm_done), .mm_src1_addr(mm_src1_addr), .mm_src2_addr(mm_src2_addr),
    .mm_dest_addr(mm_dest_addr), .mm_src1_row(mm_src1_row), .mm_src1_col(mm_src1_col),
    .mm_src2_row(mm_src2_row), .mm_src2_col(mm_src2_col), .lif_start(lif_start), .lif_done(lif_done),
    .lif_src_addr(lif_src_addr), .lif_dest_addr(lif_dest_addr), .lif_row(lif_row), .lif_col(lif_col),
    .lif_thre(lif_thre)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic kind;
    logic [2:0] layer;
    logic [7:0] step;
    logic [13:0] a0, a1, a2;
    logic [9:0] s0, s1;
    logic [15:0] s2, s3;
  } ev_t;
  ev_t ev_q[$];
  ev_t mon_e;
  int ev_cyc[$];
  int n_cmp = 0, n_fail = 0, busy_cnt = 0, rd_cnt = 0, cyc = 0;
  int mm_ack = 0, mm_busy = 20, lif_ack = 0, lif_busy = 20, mm_cnt = 0, lif_cnt = 0;
  logic last_kind = 1'b1;
  logic [15:0] tbl_m [8][8];
  logic [137:0] cfg_o, prev_cfg = '0;
  logic [152:0] all_o;
  assign cfg_o = {mm_src1_addr, mm_src2_addr, mm_dest_addr, mm_src1_row, mm_src1_col, mm_src2_row,
                  mm_src2_col, lif_src_addr, lif_dest_addr, lif_row, lif_col, lif_thre};
  assign all_o = {busy, run_done, cur_step, cur_layer, mm_start, lif_start, cfg_o};
  // Engine model: done drops after the ack delay, stays low for the busy time, then rises.
  assign mm_done = (mm_cnt == 0) || (mm_cnt > mm_busy);
  assign lif_done = (lif_cnt == 0) || (lif_cnt > lif_busy);
  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      mm_cnt <= 0;
      lif_cnt <= 0;
    end else begin
      mm_cnt <= mm_start ? mm_ack + mm_busy : (mm_cnt > 0 ? mm_cnt - 1 : 0);
      lif_cnt <= lif_start ? lif_ack + lif_busy : (lif_cnt > 0 ? lif_cnt - 1 : 0);
    end
  end
  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!reset) begin
      if (busy) busy_cnt++;
      if (run_done) rd_cnt++;
      if (mm_start || lif_start) begin
        check("start_exclusive", {159'd0, mm_start & lif_start}, 160'd0);
        check("start_alternate", {159'd0, last_kind}, {159'd0, mm_start});
        check("engine_idle_at_start", mm_start ? mm_cnt : lif_cnt, 160'd0);
        check("cfg_stable_before_start", cfg_o, prev_cfg);
        mon_e = '0;
        mon_e.kind = lif_start;
        mon_e.layer = cur_layer;
        mon_e.step = cur_step;
        if (!lif_start) begin
          mon_e.a0 = mm_src1_addr; mon_e.a1 = mm_src2_addr; mon_e.a2 = mm_dest_addr;
          mon_e.s0 = mm_src1_row; mon_e.s1 = mm_src1_col;
          mon_e.s2 = {10'd0, mm_src2_row}; mon_e.s3 = {10'd0, mm_src2_col};
        end else begin
          mon_e.a0 = lif_src_addr; mon_e.a1 = lif_dest_addr;
          mon_e.s0 = lif_row; mon_e.s1 = lif_col; mon_e.s2 = lif_thre;
        end
        ev_q.push_back(mon_e);
        ev_cyc.push_back(cyc);
        last_kind = lif_start;
      end
    end
    prev_cfg = cfg_o;
  end
  function automatic ev_t exp_ev(input logic kind, input int l, input int s);
    ev_t e = '0;
    e.kind = kind;
    e.layer = 3'(l);
    e.step = 8'(s);
    if (!kind) begin
      e.a0 = tbl_m[l][0][13:0]; e.a1 = tbl_m[l][1][13:0]; e.a2 = tbl_m[l][2][13:0];
      e.s0 = tbl_m[l][4][9:0]; e.s1 = tbl_m[l][6][9:0];
      e.s2 = {10'd0, tbl_m[l][6][5:0]}; e.s3 = {10'd0, tbl_m[l][5][5:0]};
    end else begin
      e.a0 = tbl_m[l][2][13:0]; e.a1 = tbl_m[l][3][13:0];
      e.s0 = tbl_m[l][4][9:0]; e.s1 = {4'd0, tbl_m[l][5][5:0]}; e.s2 = tbl_m[l][7];
    end
    return e;
  endfunction
  task automatic wr(input int l, input int f, input logic [15:0] v, input bit accept);
    @(negedge clk);
    cfg_we = 1'b1; cfg_layer = 3'(l); cfg_field = 3'(f); cfg_wdata = v;
    @(negedge clk);
    cfg_we = 1'b0;
    if (accept) tbl_m[l][f] = v;
  endtask
  task automatic start_run(input int nl, input int ns, output int t0);
    busy_cnt = 0; rd_cnt = 0; last_kind = 1'b1;
    ev_q.delete(); ev_cyc.delete();
    @(negedge clk);
    run_start = 1'b1; num_layers = 4'(nl); num_steps = 8'(ns); t0 = cyc;
    @(negedge clk);
    run_start = 1'b0;
  endtask
  task automatic wait_done(input string tag);
    int k = 0;
    while (rd_cnt == 0 && k < 5000) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_run_done_seen"}, {159'd0, rd_cnt > 0}, 160'd1);
    repeat (4) @(negedge clk);
  endtask
  task automatic verify_run(input int nl, input int ns, input string tag);
    int nle = nl > 8 ? 8 : nl;
    int idx = 0;
    check({tag, "_event_count"}, ev_q.size(), 2 * nle * ns);
    for (int s = 0; s < ns; s++)
      for (int l = 0; l < nle; l++)
        for (int k = 0; k < 2; k++) begin
          if (idx < ev_q.size()) check({tag, "_event"}, ev_q[idx], exp_ev(k[0], l, s));
          idx++;
        end
    check({tag, "_run_done_pulses"}, rd_cnt, 160'd1);
    check({tag, "_idle_after"}, {159'd0, busy}, 160'd0);
  endtask
  task automatic fill_random();
    for (int l = 0; l < 8; l++)
      for (int f = 0; f < 8; f++) wr(l, f, 16'($urandom), 1'b1);
  endtask
  initial begin
    int t0, n, nl, ns;
    for (int l = 0; l < 8; l++)
      for (int f = 0; f < 8; f++) tbl_m[l][f] = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {7'd0, all_o}, 160'd0);
    reset = 1'b0;
    // Single layer, single step with known sizes
    wr(0, 0, 16'h1234, 1); wr(0, 1, 16'hF0A5, 1); wr(0, 2, 16'h0777, 1); wr(0, 3, 16'h2abc, 1);
    wr(0, 4, 16'd4, 1); wr(0, 5, 16'd3, 1); wr(0, 6, 16'd5, 1); wr(0, 7, 16'd100, 1);
    start_run(1, 1, t0);
    wait_done("one");
    verify_run(1, 1, "one");
    if (ev_cyc.size() > 0) check("start_latency", ev_cyc[0] - t0, 160'd2);
    // 3 layers x 2 steps on random descriptors
    fill_random();
    mm_busy = $urandom_range(1, 8); lif_busy = $urandom_range(1, 8);
    start_run(3, 2, t0);
    wait_done("l3s2");
    verify_run(3, 2, "l3s2");
    // Random shapes, including a clamped layer count
    for (int r = 0; r < 4; r++) begin
      nl = (r == 3) ? 12 : $urandom_range(1, 8);
      ns = $urandom_range(1, 3);
      mm_busy = $urandom_range(1, 6); lif_busy = $urandom_range(1, 6);
      start_run(nl, ns, t0);
      wait_done("rand");
      verify_run(nl, ns, "rand");
    end
    // Empty runs: no launches, short busy
    start_run(0, 3, t0);
    wait_done("zero_layers");
    verify_run(0, 3, "zero_layers");
    check("zero_layers_busy_len", {159'd0, busy_cnt >= 1 && busy_cnt <= 2}, 160'd1);
    start_run(3, 0, t0);
    wait_done("zero_steps");
    verify_run(3, 0, "zero_steps");
    // Config writes and run_start during a run are ignored
    mm_busy = 10; lif_busy = 10;
    start_run(2, 1, t0);
    repeat (2) @(negedge clk);
    wr(1, 0, ~tbl_m[1][0], 0);
    wr(0, 7, ~tbl_m[0][7], 0);
    run_start = 1'b1; num_layers = 4'd5; num_steps = 8'd4;
    @(negedge clk);
    run_start = 1'b0;
    wait_done("busy_ignore");
    repeat (40) @(negedge clk);
    verify_run(2, 1, "busy_ignore");
    // Slow engine acceptance
    mm_ack = 3; lif_ack = 3; mm_busy = 4; lif_busy = 5;
    start_run(2, 2, t0);
    wait_done("slow_ack");
    verify_run(2, 2, "slow_ack");
    // Reset while LIF engine is busy
    mm_ack = 0; lif_ack = 0; mm_busy = 20; lif_busy = 20;
    start_run(1, 1, t0);
    n = 0;
    while (ev_q.size() < 2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("lif_launched_before_reset", ev_q.size(), 160'd2);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrun_reset_outputs", {7'd0, all_o}, 160'd0);
    reset = 1'b0;
    for (int l = 0; l < 8; l++)
      for (int f = 0; f < 8; f++) tbl_m[l][f] = '0;
    n = ev_q.size();
    repeat (40) @(negedge clk);
    check("no_start_after_reset", ev_q.size(), n);
    start_run(2, 1, t0);
    wait_done("post_reset");
    verify_run(2, 1, "post_reset");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
